// File: rtl/instruction_fetch_if.sv
// Fetch-unit bundle: control inputs, instruction-memory read port and the
// valid/ready handshake toward decode.
interface instruction_fetch_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
);
  logic              fetch_en;
  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_pc;
  logic [ADDR_W-1:0] im_address;
  logic              im_rd_en;
  logic [DATA_W-1:0] im_instruction;
  logic              if_valid;
  logic              if_ready;
  logic [DATA_W-1:0] if_instruction;
  logic [ADDR_W-1:0] if_pc;

  modport master (
    input  fetch_en, redirect_valid, redirect_pc, im_instruction, if_ready,
    output im_address, im_rd_en, if_valid, if_instruction, if_pc
  );

  modport slave (
    output fetch_en, redirect_valid, redirect_pc, im_instruction, if_ready,
    input  im_address, im_rd_en, if_valid, if_instruction, if_pc
  );
endinterface

// File: rtl/instruction_fetch.sv
// Instruction fetch: PC register, one-cycle-latency memory reads and a
// 2-entry {instruction, pc} FIFO toward decode, with redirect flushing.
module instruction_fetch #(
  parameter int                ADDR_W   = 8,
  parameter int                DATA_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input logic                 clk,
  input logic                 rst_n,
  instruction_fetch_if.master bus
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t            state;
  logic [ADDR_W-1:0] pc;
  logic              inflight;
  logic [ADDR_W-1:0] inflight_pc;
  logic [1:0]        count;
  logic              rd_ptr;
  logic              wr_ptr;
  logic [DATA_W-1:0] instr_mem [2];
  logic [ADDR_W-1:0] pc_mem [2];

  logic       pop;
  logic       push;
  logic       issue;
  logic [2:0] occupancy;

  // Issue only if every outstanding read is guaranteed a FIFO slot.
  assign pop       = (count != 2'd0) && bus.if_ready;
  assign push      = inflight && !bus.redirect_valid;
  assign occupancy = 3'(count) + 3'(inflight) - 3'(pop);
  assign issue     = (state == RUN) && bus.fetch_en && !bus.redirect_valid
                     && (occupancy < 3'd2);

  assign bus.im_address     = pc;
  assign bus.im_rd_en       = issue;
  assign bus.if_valid       = (count != 2'd0);
  assign bus.if_instruction = instr_mem[rd_ptr];
  assign bus.if_pc          = pc_mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      pc           <= RESET_PC;
      inflight     <= 1'b0;
      inflight_pc  <= '0;
      count        <= 2'd0;
      rd_ptr       <= 1'b0;
      wr_ptr       <= 1'b0;
      instr_mem[0] <= '0;
      instr_mem[1] <= '0;
      pc_mem[0]    <= '0;
      pc_mem[1]    <= '0;
    end else begin
      state <= bus.fetch_en ? RUN : IDLE;
      // A redirect overrides pop, push and issue and drops the pending response.
      if (bus.redirect_valid) begin
        pc       <= bus.redirect_pc;
        inflight <= 1'b0;
        count    <= 2'd0;
        rd_ptr   <= 1'b0;
        wr_ptr   <= 1'b0;
      end else begin
        if (push) begin
          instr_mem[wr_ptr] <= bus.im_instruction;
          pc_mem[wr_ptr]    <= inflight_pc;
          wr_ptr            <= ~wr_ptr;
        end
        if (pop) begin
          rd_ptr <= ~rd_ptr;
        end
        count    <= count + 2'(push) - 2'(pop);
        inflight <= issue;
        if (issue) begin
          inflight_pc <= pc;
          pc          <= pc + ADDR_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: directed scenarios plus random
// traffic compared each cycle against a queue-based reference model.
module tb_instruction_fetch;

  localparam int          ADDR_W   = 8;
  localparam int          DATA_W   = 32;
  localparam logic [7:0]  RESET_PC = 8'h00;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  instruction_fetch_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  instruction_fetch #(
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W),
    .RESET_PC(RESET_PC)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // Synchronous one-cycle instruction memory.
  always_ff @(posedge clk) begin
    if (bus.im_rd_en) bus.im_instruction <= 32'hA500_0000 | 32'(bus.im_address);
  end

  // Reference model: a queue of buffered pcs; the word for pc p is A500_0000|p.
  int m_pc;
  bit m_run;
  bit m_infl;
  int m_infl_pc;
  int q_pc[$];
  int got_pcs[$];

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic checkOutput(string tag, logic [31:0] obs, logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic checkGot(string tag, int idx, int exp);
    checkOutput(tag, (idx < got_pcs.size()) ? 32'(got_pcs[idx]) : 32'hFFFF_FFFF, 32'(exp));
  endtask

  task automatic applyStimulus(bit fe, bit rv, logic [7:0] rpc, bit rdy);
    bit pop;
    bit issue;
    int occ;
    @(negedge clk);
    rst_n              = 1'b1;
    bus.fetch_en       = fe;
    bus.redirect_valid = rv;
    bus.redirect_pc    = rpc;
    bus.if_ready       = rdy;
    #1;
    pop   = (q_pc.size() != 0) && rdy;
    occ   = q_pc.size() + int'(m_infl) - int'(pop);
    issue = m_run && fe && !rv && (occ < 2);
    checkOutput("im_rd_en", 32'(bus.im_rd_en), 32'(issue));
    checkOutput("im_address", 32'(bus.im_address), 32'(m_pc));
    checkOutput("if_valid", 32'(bus.if_valid), 32'(q_pc.size() != 0));
    if (q_pc.size() != 0) begin
      checkOutput("if_pc", 32'(bus.if_pc), 32'(q_pc[0]));
      checkOutput("if_instruction", bus.if_instruction, 32'hA500_0000 | 32'(q_pc[0]));
    end
    if (bus.if_valid && rdy && !rv) got_pcs.push_back(int'(bus.if_pc));
    if (rv) begin
      m_pc   = int'(rpc);
      m_infl = 1'b0;
      q_pc.delete();
    end else begin
      if (pop) void'(q_pc.pop_front());
      if (m_infl) q_pc.push_back(m_infl_pc);
      if (issue) begin
        m_infl_pc = m_pc;
        m_pc      = (m_pc + 1) % 256;
      end
      m_infl = issue;
    end
    m_run = fe;
    @(posedge clk);
  endtask

  task automatic doReset(int cycles);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    m_pc   = int'(RESET_PC);
    m_run  = 1'b0;
    m_infl = 1'b0;
    q_pc.delete();
    checkOutput("rst_if_valid", 32'(bus.if_valid), 32'd0);
    checkOutput("rst_im_rd_en", 32'(bus.im_rd_en), 32'd0);
    checkOutput("rst_if_pc", 32'(bus.if_pc), 32'd0);
    checkOutput("rst_if_instruction", bus.if_instruction, 32'd0);
    checkOutput("rst_im_address", 32'(bus.im_address), 32'(RESET_PC));
    repeat (cycles) @(posedge clk);
  endtask

  initial begin
    bus.fetch_en       = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    bus.if_ready       = 1'b0;

    doReset(2);

    // Free-running stream from reset.
    got_pcs.delete();
    repeat (8) applyStimulus(1'b1, 1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 4; i++) checkGot("stream_pc", i, i);

    // Decode stalls: at most two reads outstanding, nothing lost.
    doReset(1);
    repeat (3) applyStimulus(1'b1, 1'b0, 8'h00, 1'b1);
    repeat (5) applyStimulus(1'b1, 1'b0, 8'h00, 1'b0);
    got_pcs.delete();
    repeat (4) applyStimulus(1'b1, 1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 3; i++) checkGot("stall_pc", i, i);

    // Redirect with a read in flight.
    applyStimulus(1'b1, 1'b1, 8'h40, 1'b1);
    got_pcs.delete();
    repeat (4) applyStimulus(1'b1, 1'b0, 8'h00, 1'b1);
    checkGot("redirect_pc", 0, 'h40);

    // PC wrap.
    applyStimulus(1'b1, 1'b1, 8'hFE, 1'b1);
    got_pcs.delete();
    repeat (7) applyStimulus(1'b1, 1'b0, 8'h00, 1'b1);
    checkGot("wrap_pc0", 0, 'hFE);
    checkGot("wrap_pc1", 1, 'hFF);
    checkGot("wrap_pc2", 2, 'h00);
    checkGot("wrap_pc3", 3, 'h01);

    // fetch_en falls with one buffered and one in flight.
    got_pcs.delete();
    repeat (5) applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
    checkOutput("drain_count", 32'(got_pcs.size()), 32'd2);

    // Reset mid-stream with a full FIFO.
    repeat (3) applyStimulus(1'b1, 1'b0, 8'h00, 1'b1);
    repeat (4) applyStimulus(1'b1, 1'b0, 8'h00, 1'b0);
    checkOutput("full_before_reset", 32'(bus.if_valid), 32'd1);
    doReset(1);
    got_pcs.delete();
    repeat (6) applyStimulus(1'b1, 1'b0, 8'h00, 1'b1);
    checkGot("post_reset_pc", 0, int'(RESET_PC));

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 99) == 0) doReset(1);
      applyStimulus($urandom_range(0, 9) != 0, $urandom_range(0, 15) == 0,
                    8'($urandom), $urandom_range(0, 3) != 0);
    end

    $display("[TB] random phase complete");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, instruction word-address width.
REQ-002 SHALL have parameter DATA_W, default 32, instruction width.
REQ-003 SHALL have parameter RESET_PC, default 0, PC value loaded on reset.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port fetch_en  input  1  permits new memory reads while high.
REQ-007 SHALL have port redirect_valid  input  1  branch/jump request, single-cycle pulse.
REQ-008 SHALL have port redirect_pc  input  ADDR_W  target word address, qualified by redirect_valid.
REQ-009 SHALL have port im_address  output  ADDR_W  address to instruction memory, equal to the PC register.
REQ-010 SHALL have port im_rd_en  output  1  high in each cycle a read is issued (combinational).
REQ-011 SHALL have port im_instruction  input  DATA_W  memory read data, valid exactly 1 cycle after issue.
REQ-012 SHALL have port if_valid  output  1  instruction available to decode.
REQ-013 SHALL have port if_ready  input  1  decode accepts head instruction.
REQ-014 SHALL have port if_instruction  output  DATA_W  head instruction.
REQ-015 SHALL have port if_pc  output  ADDR_W  word address of head instruction.

Function
REQ-016 SHALL hold a 2-entry FIFO of {instruction, pc} pairs; if_valid = (count != 0); if_instruction/if_pc show the head entry.
REQ-017 SHALL pop the head when if_valid && if_ready; head/pc SHALL stay stable while if_valid && !if_ready.
REQ-018 SHALL implement states IDLE and RUN: IDLE -> RUN when fetch_en=1; RUN -> IDLE when fetch_en=0; redirect does not change state.
REQ-019 SHALL issue (im_rd_en=1) in RUN when redirect_valid=0 and (count + inflight - pop) < 2.
REQ-020 SHALL, on issue, set inflight=1 with inflight_pc = PC, and advance PC by 1 at the same edge.
REQ-021 SHALL wrap PC from 2^ADDR_W-1 to 0 without any flag or stall.
REQ-022 SHALL, in the cycle after an issue, push {im_instruction, inflight_pc} into the FIFO and clear inflight unless a new issue occurs.
REQ-023 SHALL allow push and pop in the same cycle with count unchanged; sustained throughput 1 instruction/cycle when if_ready=1.
REQ-024 SHALL never overflow: issue gating guarantees a FIFO slot for every in-flight read.
REQ-025 SHALL, on redirect_valid=1: load PC <= redirect_pc, flush FIFO (count=0), discard any in-flight response (inflight=0, no push next cycle), not issue that cycle; redirect takes priority over pop, push and issue.
REQ-026 SHALL, when fetch_en falls, stop issuing immediately; an in-flight read still completes and the FIFO still drains.
REQ-027 SHALL issue from redirect_pc in the cycle after the redirect if RUN and fetch_en=1.

Reset
REQ-028 SHALL, while rst_n=0, asynchronously force PC=RESET_PC, state=IDLE, count=0, inflight=0, if_valid=0, im_rd_en=0, if_instruction=0, if_pc=0.
REQ-029 SHALL discard any read in flight when reset asserts mid-operation; first issue after release is from RESET_PC.

Verification
Memory model: synchronous 1-cycle read returning 32'hA500_0000 | address.
REQ-030 Reset release, fetch_en=1, if_ready=1 -> im_address 0,1,2,3 on consecutive cycles; if_instruction 32'hA500_0000..32'hA500_0003 with if_pc 0..3, one per cycle, first valid 2 cycles after release.
REQ-031 if_ready=0 for 5 cycles after first valid -> exactly 2 reads issued, FIFO holds pc 0 and 1, im_rd_en=0 thereafter; on if_ready=1, pc 0,1,2 delivered in order, none lost or duplicated.
REQ-032 redirect_valid=1 with redirect_pc=8'h40 while an instruction is in flight -> FIFO flushed, in-flight word never presented, next if_pc=8'h40 with 32'hA500_0040.
REQ-033 redirect_pc=8'hFE, free-running -> if_pc sequence FE, FF, 00, 01.
REQ-034 fetch_en dropped with 1 in flight and 1 buffered -> no further im_rd_en; both delivered; if_valid then stays 0.
REQ-035 rst_n pulsed low mid-stream with count=2 -> if_valid=0 immediately; after release, first if_pc=RESET_PC.
